// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Multi-entry register file for the 8-bit CPU datapath. One write port and
// two independent registered read ports feeding ALU operands A and B.
//
// Storage follows the single-register semantics: asynchronous clear, and a
// load on the rising clock edge only when we=1. Reads are synchronous, with
// one cycle of latency and a per-port valid flag. A read and a write to the
// same address on the same edge return the new write data (write-first bypass).
//
// Optional build macro:
//   REGFILE_ZERO_REG_EN - entry 0 is hard-wired to zero. Writes to address 0
//                         are dropped, and reads of address 0 return 0 even
//                         when a write to address 0 lands on the same edge.
//
// Ports:
//   clk       in   1       clock, all state updates on the rising edge
//   rst       in   1       asynchronous active-high reset
//   we        in   1       write enable
//   waddr     in   ADDR_W  write address
//   wdata     in   WIDTH   write data
//   re_a      in   1       read request, port A
//   raddr_a   in   ADDR_W  read address, port A
//   rdata_a   out  WIDTH   registered read data, port A
//   rvalid_a  out  1       rdata_a was loaded by a read on the previous edge
//   re_b      in   1       read request, port B
//   raddr_b   in   ADDR_W  read address, port B
//   rdata_b   out  WIDTH   registered read data, port B
//   rvalid_b  out  1       rdata_b was loaded by a read on the previous edge
// -----------------------------------------------------------------------------
module register_file #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    output logic              rvalid_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              rvalid_b
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [WIDTH-1:0] mem [NUM_REGS];

    logic [WIDTH-1:0] rd_a_p1;
    logic [WIDTH-1:0] rd_b_p1;
    logic             vld_a_p1;
    logic             vld_b_p1;

    // True when the given address is the hard-wired zero entry.
    function automatic logic is_zero_entry(input logic [ADDR_W-1:0] addr);
`ifdef REGFILE_ZERO_REG_EN
        return (addr == '0);
`else
        return 1'b0;
`endif
    endfunction

    // Write-first read: a same-edge write to the same address wins over the
    // stored value. The zero entry always reads 0 and never bypasses.
    function automatic logic [WIDTH-1:0] read_entry(input logic [ADDR_W-1:0] addr);
        if (is_zero_entry(addr))
            return '0;
        else if (we && (waddr == addr))
            return wdata;
        else
            return mem[addr];
    endfunction

    logic wr_en;
    assign wr_en = we && !is_zero_entry(waddr);

    // Stage p0 -> p1: storage update and registered read of both ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
            rd_a_p1  <= '0;
            rd_b_p1  <= '0;
            vld_a_p1 <= 1'b0;
            vld_b_p1 <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[waddr] <= wdata;
            end
            if (re_a) begin
                rd_a_p1 <= read_entry(raddr_a);
            end
            if (re_b) begin
                rd_b_p1 <= read_entry(raddr_b);
            end
            vld_a_p1 <= re_a;
            vld_b_p1 <= re_b;
        end
    end

    assign rdata_a  = rd_a_p1;
    assign rvalid_a = vld_a_p1;
    assign rdata_b  = rd_b_p1;
    assign rvalid_b = vld_b_p1;

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//
// Directed self-checking bench for register_file. Inputs change 1 time unit
// after each rising edge; outputs are sampled at that same point, well away
// from the active edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_register_file;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic              re_a;
    logic [ADDR_W-1:0] raddr_a;
    logic [WIDTH-1:0]  rdata_a;
    logic              rvalid_a;
    logic              re_b;
    logic [ADDR_W-1:0] raddr_b;
    logic [WIDTH-1:0]  rdata_b;
    logic              rvalid_b;

    int checks;
    int failures;

    register_file #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re_a     (re_a),
        .raddr_a  (raddr_a),
        .rdata_a  (rdata_a),
        .rvalid_a (rvalid_a),
        .re_b     (re_b),
        .raddr_b  (raddr_b),
        .rdata_b  (rdata_b),
        .rvalid_b (rvalid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we      = 1'b0;
        re_a    = 1'b0;
        re_b    = 1'b0;
    endtask

    // Value written to entry i in the sweep; what a read of entry i returns.
    function automatic logic [WIDTH-1:0] sweep_val(input int i);
        return 8'(i * 8'h11 + 8'h03);
    endfunction

    function automatic logic [WIDTH-1:0] sweep_exp(input int i);
`ifdef REGFILE_ZERO_REG_EN
        if (i == 0) return 8'h00;
`endif
        return sweep_val(i);
    endfunction

    logic [WIDTH-1:0] exp_zero_77;
    logic [WIDTH-1:0] exp_zero_88;

    initial begin
        checks   = 0;
        failures = 0;
`ifdef REGFILE_ZERO_REG_EN
        exp_zero_77 = 8'h00;
        exp_zero_88 = 8'h00;
`else
        exp_zero_77 = 8'h77;
        exp_zero_88 = 8'h88;
`endif

        // Reset held across edges with write and reads requested.
        rst     = 1'b1;
        we      = 1'b1;
        waddr   = 3'd3;
        wdata   = 8'hFF;
        re_a    = 1'b1;
        raddr_a = 3'd3;
        re_b    = 1'b1;
        raddr_b = 3'd3;
        tick();
        tick();
        check("rst_rdata_a",  32'(rdata_a),  32'h00);
        check("rst_rdata_b",  32'(rdata_b),  32'h00);
        check("rst_rvalid_a", 32'(rvalid_a), 32'h0);
        check("rst_rvalid_b", 32'(rvalid_b), 32'h0);

        rst = 1'b0;
        we  = 1'b0;
        re_b = 1'b0;
        tick();
        check("post_rst_addr3",   32'(rdata_a),  32'h00);
        check("post_rst_rvalid",  32'(rvalid_a), 32'h1);

        // Plain write then read with 1-cycle latency.
        idle();
        we = 1'b1; waddr = 3'd5; wdata = 8'hA5;
        tick();
        we = 1'b0; re_a = 1'b1; raddr_a = 3'd5;
        tick();
        check("rd5_data",   32'(rdata_a),  32'hA5);
        check("rd5_valid",  32'(rvalid_a), 32'h1);
        check("rd5_valid_b_idle", 32'(rvalid_b), 32'h0);
        re_a = 1'b0;
        tick();
        check("rd5_drop_valid", 32'(rvalid_a), 32'h0);
        check("rd5_hold_data",  32'(rdata_a),  32'hA5);

        // Same-edge bypass on both ports.
        we = 1'b1; waddr = 3'd2; wdata = 8'h3C;
        re_a = 1'b1; raddr_a = 3'd2;
        re_b = 1'b1; raddr_b = 3'd2;
        tick();
        check("byp_a",       32'(rdata_a),  32'h3C);
        check("byp_b",       32'(rdata_b),  32'h3C);
        check("byp_valid_a", 32'(rvalid_a), 32'h1);
        check("byp_valid_b", 32'(rvalid_b), 32'h1);
        we = 1'b0; wdata = 8'hEE;
        tick();
        check("b2b_a",       32'(rdata_a),  32'h3C);
        check("b2b_valid_a", 32'(rvalid_a), 32'h1);
        check("b2b_valid_b", 32'(rvalid_b), 32'h1);

        // Independent ports, and we=0 must not write.
        idle();
        we = 1'b1; waddr = 3'd1; wdata = 8'h11;
        tick();
        waddr = 3'd6; wdata = 8'h66;
        tick();
        we = 1'b0;
        re_a = 1'b1; raddr_a = 3'd1;
        re_b = 1'b1; raddr_b = 3'd6;
        tick();
        check("dual_a", 32'(rdata_a), 32'h11);
        check("dual_b", 32'(rdata_b), 32'h66);
        we = 1'b0; waddr = 3'd1; wdata = 8'h99;
        re_a = 1'b1; raddr_a = 3'd1;
        re_b = 1'b0;
        tick();
        check("no_we_addr1",   32'(rdata_a),  32'h11);
        check("b_hold_data",   32'(rdata_b),  32'h66);
        check("b_drop_valid",  32'(rvalid_b), 32'h0);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        idle();
        we = 1'b1; waddr = 3'd4; wdata = 8'h5A;
        tick();
        we = 1'b0; re_a = 1'b1; raddr_a = 3'd4;
        tick();
        check("pre_arst_a", 32'(rdata_a), 32'h5A);
        re_a = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_rdata_a",  32'(rdata_a),  32'h00);
        check("arst_rdata_b",  32'(rdata_b),  32'h00);
        check("arst_rvalid_a", 32'(rvalid_a), 32'h0);
        check("arst_rvalid_b", 32'(rvalid_b), 32'h0);
        #1;
        rst = 1'b0;
        re_a = 1'b1; raddr_a = 3'd4;
        re_b = 1'b1; raddr_b = 3'd5;
        tick();
        check("arst_addr4", 32'(rdata_a), 32'h00);
        check("arst_addr5", 32'(rdata_b), 32'h00);

        // Address 0: ordinary entry, or hard-wired zero when enabled.
        idle();
        we = 1'b1; waddr = 3'd0; wdata = 8'h77;
        tick();
        we = 1'b0; re_a = 1'b1; raddr_a = 3'd0;
        tick();
        check("addr0_read",  32'(rdata_a),  32'(exp_zero_77));
        check("addr0_valid", 32'(rvalid_a), 32'h1);
        we = 1'b1; waddr = 3'd0; wdata = 8'h88;
        re_a = 1'b1; raddr_a = 3'd0;
        re_b = 1'b1; raddr_b = 3'd0;
        tick();
        check("addr0_byp_a", 32'(rdata_a), 32'(exp_zero_88));
        check("addr0_byp_b", 32'(rdata_b), 32'(exp_zero_88));
        check("addr0_byp_valid_b", 32'(rvalid_b), 32'h1);

        // Sweep: every encoding is a distinct entry.
        idle();
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; waddr = 3'(i); wdata = sweep_val(i);
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            re_a = 1'b1; raddr_a = 3'(i);
            re_b = 1'b1; raddr_b = 3'(7 - i);
            tick();
            check($sformatf("sweep_a%0d", i), 32'(rdata_a), 32'(sweep_exp(i)));
            check($sformatf("sweep_b%0d", 7 - i), 32'(rdata_b), 32'(sweep_exp(7 - i)));
        end
        idle();
        tick();
        check("final_valid_a", 32'(rvalid_a), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Multi-entry register file for the 8-bit CPU datapath: one write port (writer side), two independent registered read ports (reader side) feeding ALU operands A and B.
- Built on the same write-enable storage semantics as the single register: async clear, load on clock edge only when we=1.
- Adds synchronous read with a read-valid flag and write-to-read bypass, so a read issued in the same cycle as a write to that address returns the new data.

Parameters:
- WIDTH, 8, data width of each entry and of all data ports
- ADDR_W, 3, address width; entry count NUM_REGS = 2**ADDR_W (localparam, 8 by default)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- re_a  input  1  read request, port A
- raddr_a  input  ADDR_W  read address, port A
- rdata_a  output  WIDTH  registered read data, port A
- rvalid_a  output  1  rdata_a updated by a read on the previous edge
- re_b  input  1  read request, port B
- raddr_b  input  ADDR_W  read address, port B
- rdata_b  output  WIDTH  registered read data, port B
- rvalid_b  output  1  rdata_b updated by a read on the previous edge

Behaviour:
- Reset (rst=1, asynchronous, no clock needed): every entry = 0; rdata_a = rdata_b = 0; rvalid_a = rvalid_b = 0. While rst is held, edges have no effect.
- Reset mid-operation: any write or read sampled on the same edge is discarded. First rising edge after deassertion operates normally.
- Write, rising edge, rst=0:
  - we=1: entry[waddr] <= wdata.
  - we=0: storage unchanged.
- Read, each port independent, rising edge, rst=0:
  - re_x=1: rdata_x <= entry[raddr_x]; rvalid_x <= 1.
  - re_x=0: rdata_x holds its previous value; rvalid_x <= 0.
- Latency: exactly 1 cycle from the re_x/raddr_x sample to rdata_x/rvalid_x.
- Bypass (write-first): if we=1, re_x=1 and waddr==raddr_x on the same edge, rdata_x <= wdata, not the stale entry.
- Both ports reading the same address on the same edge return identical data, including under bypass.
- Back-to-back reads every cycle are allowed; rvalid_x stays 1 continuously.
- No address is out of range: all 2**ADDR_W encodings are valid entries.
- Outputs come directly from flops; there is no combinational path from any input to any output.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN
- Defined:
  - entry 0 is hard-wired to zero; writes to waddr=0 are ignored.
  - reads of address 0 return 0, including when a write to address 0 occurs on the same edge (no bypass for address 0).
  - rvalid behaviour is unchanged.
- Not defined: entry 0 is an ordinary storage entry, same as all others.

Test Plan:
- rst=1 with we=1, waddr=3, wdata=8'hFF, re_a=re_b=1 for 2 edges -> rdata_a=rdata_b=8'h00, rvalid_a=rvalid_b=0; after release, reading addr 3 returns 8'h00.
- Write addr 5 = 8'hA5 (we=1, one edge), then we=0, re_a=1, raddr_a=5 -> one edge later rdata_a=8'hA5, rvalid_a=1; next edge with re_a=0 -> rvalid_a=0, rdata_a stays 8'hA5.
- Same edge: we=1, waddr=2, wdata=8'h3C, re_a=1, raddr_a=2, re_b=1, raddr_b=2 -> rdata_a=rdata_b=8'h3C (bypass), rvalid both 1.
- Write addr 1 = 8'h11 and addr 6 = 8'h66, then read A=1, B=6 on the same edge -> rdata_a=8'h11, rdata_b=8'h66; then we=0, wdata=8'h99, waddr=1 -> re-read addr 1 still gives 8'h11.
- Assert rst asynchronously mid-cycle after addr 4 = 8'h5A -> all outputs go to 0 immediately without a clock edge; subsequent read of addr 4 returns 8'h00.
- Write addr 0 = 8'h77, then read addr 0 -> 8'h77 without REGFILE_ZERO_REG_EN; 8'h00 with it, including the same-edge bypass case.
